codificador_sequencia: RTL and testbench
========================================

// Module: codificador_sequencia
// PURPOSE
//   Transmit-side counterpart of the character decoder. Turns high-level commands (go to
//   state N, terminate, abort) into the 7-bit character stream the decoder consumes.
//   Emits one character per handshake and keeps a model of the decoder's state so that
//   forward, correction and termination codes are always legal. Sits between the
//   control/test sequencer and the decoder's Entrada/Controle inputs.
// PARAMETERS
//   INTER_GAP  0          idle cycles forced after each accepted char (0..15)
//   IDLE_CHAR  7'b0000000 value driven on Saida when char_valid=0
// PORTS
//   clk         in   1  single clock, rising edge
//   Reset       in   1  asynchronous, active-low; clears all state
//   cmd_valid   in   1  command request
//   cmd_ready   out  1  high only in IDLE; command accepted on cmd_valid&cmd_ready
//   cmd_op      in   2  00 GOTO, 01 TERMINATE, 10 ABORT, 11 reserved(illegal)
//   cmd_target  in   3  GOTO target state, legal 1..5
//   Saida       out  7  character to decoder Entrada
//   char_valid  out  1  Saida holds a character
//   char_ready  in   1  downstream takes char on char_valid&char_ready
//   Controle    out  1  high from accept until done; drives decoder Controle
//   model_state out  3  modelled decoder state 0..5 (0 = initial)
//   done        out  1  1-cycle pulse when command complete
//   err         out  1  1-cycle pulse on illegal command (command dropped)
// BEHAVIOUR
//   Codes: C1 1100000 C2 1000100 C3 1111100 C4 1011010 C5 1101110
//          C6 1001001 C7 1110101 C8 1010011.  Cn (n=1..5) <=> state n.
//   Reset (Reset=0, async): FSM=IDLE, model_state=0, Saida=IDLE_CHAR, char_valid=0,
//     Controle=0, done=0, err=0, cmd_ready=1 after release. Partial sequence dropped.
//   FSM: IDLE -> SEND -> (GAP if INTER_GAP>0) -> SEND ... -> IDLE.
//   Accept in IDLE, cycle k. Illegal (op=11; GOTO target 0 or >5; TERMINATE at model 0):
//     err=1 at k+1, no chars, Controle stays 0, stay IDLE.
//   GOTO t=model: no chars; done=1 at k+1; Controle high for cycle k+1 only.
//   GOTO t>m: emit C(m+1),C(m+2)..C(t) ascending. From 0 starts at C1.
//   GOTO t<m: correction, emit C(m-1)..C(t) descending.
//   TERMINATE: C6 if model in 1..3, C8 if 4..5; model->0 on handshake.
//   ABORT: emit C7 from any model state (incl 0); model->0 on handshake.
//   First char_valid=1 at cycle k+1 (1-cycle latency). Saida/char_valid held stable
//     while char_valid&!char_ready; no char dropped or repeated.
//   model_state updates in the cycle after each handshake to that char's state.
//   After a handshake: if more chars and INTER_GAP=0, next char valid next cycle
//     (back-to-back, 1 char/cycle); else INTER_GAP cycles char_valid=0, Saida=IDLE_CHAR.
//   Last char handshake -> done=1 next cycle, Controle=0 same cycle, FSM=IDLE,
//     cmd_ready=1. No command accepted while busy (cmd_ready=0 in SEND/GAP).
//   Step count max 5; internal step counter 3 bits, no wrap possible.
// TESTING
//   1 Reset low mid-GOTO 5 after C2 sent -> all outputs reset values, model_state=0.
//   2 GOTO 5 from 0, char_ready=1, INTER_GAP=0 -> C1..C5 on 5 consecutive cycles from
//     k+1, done at k+6, model_state=5.
//   3 model 5, GOTO 1 -> C4,C3,C2,C1 descending; model_state 4,3,2,1; then TERMINATE
//     -> C6, model_state=0.
//   4 model 4, TERMINATE with char_ready low 3 cycles -> C8 held 3 cycles, one transfer,
//     model 0.
//   5 model 0: TERMINATE -> err pulse, no char; GOTO 0 / GOTO 6 / op=11 -> err each;
//     ABORT -> C7, done, model 0.
//   6 INTER_GAP=2, GOTO 3 from 0 -> C1,gap,gap,C2,gap,gap,C3; Saida=IDLE_CHAR in gaps.

Source files
------------

// File: rtl/codificador_sequencia.sv
`default_nettype none
// codificador_sequencia: turns GOTO/TERMINATE/ABORT commands into the 7-bit character
// stream of the sequence decoder, tracking the decoder state so every emitted code is legal.
module codificador_sequencia #(
  parameter int unsigned INTER_GAP = 0,
  parameter logic [6:0]  IDLE_CHAR = 7'b0000000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_target,
  output logic [6:0] Saida,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       Controle,
  output logic [2:0] model_state,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] OP_GOTO  = 2'b00;
  localparam logic [1:0] OP_TERM  = 2'b01;
  localparam logic [1:0] OP_ABORT = 2'b10;
  localparam bit         HAS_GAP  = (INTER_GAP != 0);
  localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(INTER_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Character ids: 1..5 are forward codes for decoder states, 6/7/8 terminate/abort codes.
  function automatic logic [6:0] code_of(input logic [3:0] id);
    case (id)
      4'd1:    code_of = 7'b1100000;
      4'd2:    code_of = 7'b1000100;
      4'd3:    code_of = 7'b1111100;
      4'd4:    code_of = 7'b1011010;
      4'd5:    code_of = 7'b1101110;
      4'd6:    code_of = 7'b1001001;
      4'd7:    code_of = 7'b1110101;
      4'd8:    code_of = 7'b1010011;
      default: code_of = IDLE_CHAR;
    endcase
  endfunction

  function automatic logic [2:0] state_of(input logic [3:0] id);
    state_of = (id >= 4'd1 && id <= 4'd5) ? id[2:0] : 3'd0;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] model_q, model_d;
  logic [3:0] cur_q, cur_d;
  logic [3:0] tgt_q, tgt_d;
  logic       up_q, up_d;
  logic [3:0] gap_q, gap_d;
  logic [6:0] saida_q, saida_d;
  logic       valid_q, valid_d;
  logic       ctl_q, ctl_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       legal, noop, up_new;
  logic [3:0] first, tgt_new, next_id;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      model_q <= 3'd0;
      cur_q   <= 4'd0;
      tgt_q   <= 4'd0;
      up_q    <= 1'b0;
      gap_q   <= 4'd0;
      saida_q <= IDLE_CHAR;
      valid_q <= 1'b0;
      ctl_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      model_q <= model_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      up_q    <= up_d;
      gap_q   <= gap_d;
      saida_q <= saida_d;
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    model_d = model_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    up_d    = up_q;
    gap_d   = gap_q;
    saida_d = saida_q;
    valid_d = valid_q;
    ctl_d   = ctl_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    legal   = 1'b0;
    noop    = 1'b0;
    up_new  = 1'b0;
    first   = 4'd0;
    tgt_new = 4'd0;
    next_id = up_q ? cur_q + 4'd1 : cur_q - 4'd1;

    case (state_q)
      S_IDLE: begin
        ctl_d = 1'b0;
        if (cmd_valid) begin
          case (cmd_op)
            OP_GOTO: begin
              if (cmd_target >= 3'd1 && cmd_target <= 3'd5) begin
                legal   = 1'b1;
                tgt_new = {1'b0, cmd_target};
                if (cmd_target == model_q) begin
                  noop = 1'b1;
                end else if (cmd_target > model_q) begin
                  up_new = 1'b1;
                  first  = {1'b0, model_q} + 4'd1;
                end else begin
                  first  = {1'b0, model_q} - 4'd1;
                end
              end
            end
            OP_TERM: begin
              if (model_q != 3'd0) begin
                legal   = 1'b1;
                first   = (model_q <= 3'd3) ? 4'd6 : 4'd8;
                tgt_new = first;
              end
            end
            OP_ABORT: begin
              legal   = 1'b1;
              first   = 4'd7;
              tgt_new = 4'd7;
            end
            default: ;
          endcase

          if (!legal) begin
            err_d = 1'b1;
          end else if (noop) begin
            done_d = 1'b1;
            ctl_d  = 1'b1;
          end else begin
            state_d = S_SEND;
            cur_d   = first;
            tgt_d   = tgt_new;
            up_d    = up_new;
            saida_d = code_of(first);
            valid_d = 1'b1;
            ctl_d   = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (char_ready) begin
          model_d = state_of(cur_q);
          if (cur_q == tgt_q) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            saida_d = IDLE_CHAR;
            ctl_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            cur_d = next_id;
            if (HAS_GAP) begin
              state_d = S_GAP;
              valid_d = 1'b0;
              saida_d = IDLE_CHAR;
              gap_d   = GAP_LOAD;
            end else begin
              saida_d = code_of(next_id);
            end
          end
        end
      end

      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = S_SEND;
          valid_d = 1'b1;
          saida_d = code_of(cur_q);
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign Saida       = saida_q;
  assign char_valid  = valid_q;
  assign Controle    = ctl_q;
  assign model_state = model_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_codificador_sequencia.sv
`default_nettype none
// Bench for codificador_sequencia: directed scenarios plus random commands checked
// against a list-based model of the character sequence each command must produce.
module tb_codificador_sequencia;

  logic       clk = 1'b0;
  logic       Reset;
  logic       cmd_valid, char_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_target;
  logic       cmd_ready, char_valid, Controle, done, err;
  logic [6:0] Saida;
  logic [2:0] model_state;

  logic       cmd_valid2;
  logic [1:0] cmd_op2;
  logic [2:0] cmd_target2;
  logic       cmd_ready2, char_valid2, Controle2, done2, err2;
  logic [6:0] Saida2;
  logic [2:0] model_state2;

  int total = 0;
  int bad   = 0;
  int mdl   = 0;
  int expq[$];

  logic [6:0] codes [1:8] = '{7'b1100000, 7'b1000100, 7'b1111100, 7'b1011010,
                              7'b1101110, 7'b1001001, 7'b1110101, 7'b1010011};

  always #5 clk = ~clk;

  codificador_sequencia #(.INTER_GAP(0), .IDLE_CHAR(7'b0000000)) dut0 (
    .clk(clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_target(cmd_target), .Saida(Saida), .char_valid(char_valid),
    .char_ready(char_ready), .Controle(Controle), .model_state(model_state),
    .done(done), .err(err)
  );

  codificador_sequencia #(.INTER_GAP(2), .IDLE_CHAR(7'b0000000)) dut2 (
    .clk(clk), .Reset(Reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op2), .cmd_target(cmd_target2), .Saida(Saida2), .char_valid(char_valid2),
    .char_ready(1'b1), .Controle(Controle2), .model_state(model_state2),
    .done(done2), .err(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int st_of(input int id);
    return (id <= 5) ? id : 0;
  endfunction

  // Expected character list for a command issued with the decoder in state m.
  task automatic plan(input int m, input int op, input int t, output bit il, output bit noop);
    expq.delete();
    il   = 1'b0;
    noop = 1'b0;
    if (op == 0) begin
      if (t < 1 || t > 5) il = 1'b1;
      else if (t == m) noop = 1'b1;
      else if (t > m) for (int i = m + 1; i <= t; i++) expq.push_back(i);
      else for (int i = m - 1; i >= t; i--) expq.push_back(i);
    end else if (op == 1) begin
      if (m == 0) il = 1'b1;
      else expq.push_back((m <= 3) ? 6 : 8);
    end else if (op == 2) begin
      expq.push_back(7);
    end else begin
      il = 1'b1;
    end
  endtask

  task automatic run_cmd(input int op, input int t, input int stall_first, input bit rnd);
    bit il, noop;
    int st, n;
    plan(mdl, op, t, il, noop);
    cmd_valid  = 1'b1;
    cmd_op     = 2'(op);
    cmd_target = 3'(t);
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    if (il) begin
      chk("err_pulse", err, 1);
      chk("err_no_char", char_valid, 0);
      chk("err_ctl", Controle, 0);
      step();
      chk("err_clear", err, 0);
      chk("err_model", model_state, 8'(mdl));
      chk("err_ready", cmd_ready, 1);
    end else if (noop) begin
      chk("noop_done", done, 1);
      chk("noop_ctl", Controle, 1);
      chk("noop_no_char", char_valid, 0);
      step();
      chk("noop_done_clr", done, 0);
      chk("noop_ctl_clr", Controle, 0);
      chk("noop_model", model_state, 8'(mdl));
    end else begin
      n = expq.size();
      for (int i = 0; i < n; i++) begin
        st = (i == 0) ? stall_first : (rnd ? int'($urandom_range(0, 2)) : 0);
        if (i == 0) chk("first_err", err, 0);
        chk("char_valid", char_valid, 1);
        chk("saida", Saida, codes[expq[i]]);
        chk("ctl_busy", Controle, 1);
        chk("busy_ready", cmd_ready, 0);
        for (int s = 0; s < st; s++) begin
          char_ready = 1'b0;
          step();
          chk("hold_valid", char_valid, 1);
          chk("hold_saida", Saida, codes[expq[i]]);
        end
        char_ready = 1'b1;
        step();
        char_ready = 1'b0;
        chk("model_step", model_state, 8'(st_of(expq[i])));
        if (i < n - 1) begin
          chk("done_early", done, 0);
        end else begin
          chk("done_pulse", done, 1);
          chk("ctl_low", Controle, 0);
          chk("valid_low", char_valid, 0);
          chk("saida_idle", Saida, 0);
          chk("ready_back", cmd_ready, 1);
        end
      end
      mdl = st_of(expq[n - 1]);
      step();
      chk("done_clr", done, 0);
    end
  endtask

  initial begin
    int ev[$];
    int es[$];
    Reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 2'd0;
    cmd_target  = 3'd0;
    char_ready  = 1'b0;
    cmd_valid2  = 1'b0;
    cmd_op2     = 2'd0;
    cmd_target2 = 3'd0;
    step(); step();
    chk("rst_model", model_state, 0);
    chk("rst_valid", char_valid, 0);
    chk("rst_saida", Saida, 0);
    chk("rst_ctl", Controle, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    Reset = 1'b1;
    step();
    chk("rst_ready", cmd_ready, 1);

    // Reset asserted in the middle of GOTO 5 after C2 has been transferred
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_target = 3'd5;
    step();
    cmd_valid  = 1'b0;
    char_ready = 1'b1;
    step(); step();
    char_ready = 1'b0;
    chk("mid_model2", model_state, 2);
    chk("mid_saida_c3", Saida, codes[3]);
    Reset = 1'b0;
    #1;
    chk("async_valid", char_valid, 0);
    chk("async_saida", Saida, 0);
    chk("async_ctl", Controle, 0);
    chk("async_model", model_state, 0);
    chk("async_done", done, 0);
    step(); step();
    Reset = 1'b1;
    step();
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_valid", char_valid, 0);
    mdl = 0;

    run_cmd(0, 5, 0, 0);          // C1..C5 back to back
    run_cmd(0, 1, 0, 0);          // C4..C1 correction
    run_cmd(1, 0, 0, 0);          // C6
    run_cmd(0, 4, 0, 0);
    run_cmd(0, 4, 0, 0);          // already there
    run_cmd(1, 0, 3, 0);          // C8 with 3-cycle stall
    run_cmd(1, 0, 0, 0);          // terminate at state 0
    run_cmd(0, 0, 0, 0);
    run_cmd(0, 6, 0, 0);
    run_cmd(3, 2, 0, 0);
    run_cmd(2, 0, 0, 0);          // C7 from state 0

    // INTER_GAP=2 instance: GOTO 3 from 0
    for (int id = 1; id <= 3; id++) begin
      ev.push_back(1); es.push_back(int'(codes[id]));
      if (id < 3) for (int g = 0; g < 2; g++) begin ev.push_back(0); es.push_back(0); end
    end
    cmd_valid2 = 1'b1; cmd_op2 = 2'd0; cmd_target2 = 3'd3;
    chk("gap_cmd_ready", cmd_ready2, 1);
    step();
    cmd_valid2 = 1'b0;
    foreach (ev[i]) begin
      chk("gap_valid", char_valid2, 8'(ev[i]));
      chk("gap_saida", Saida2, 8'(es[i]));
      chk("gap_ctl", Controle2, 1);
      step();
    end
    chk("gap_done", done2, 1);
    chk("gap_model", model_state2, 3);
    chk("gap_ctl_low", Controle2, 0);

    for (int r = 0; r < 40; r++)
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 2)), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
